ram_req_bridge: RTL and testbench
=================================

RAM_REQ_BRIDGE -- requirements
Module: ram_req_bridge

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 131072, meaning the number of 32-bit words in the attached RAM.
REQ-002 SHALL have parameter ADDR_W, default 19, meaning the RAM word-address width.
REQ-003 SHALL have ports: clk  in  1  single clock, all logic rising-edge.
REQ-004 SHALL have ports: resetn  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: req_valid  in  1  request present.
REQ-006 SHALL have ports: req_ready  out  1  request accepted when high with req_valid.
REQ-007 SHALL have ports: req_we  in  1  1=write, 0=read.
REQ-008 SHALL have ports: req_wstrb  in  4  byte enables for writes, bit n covers wdata[8n+7:8n].
REQ-009 SHALL have ports: req_addr  in  ADDR_W+2  byte address.
REQ-010 SHALL have ports: req_wdata  in  32  write data.
REQ-011 SHALL have ports: rsp_valid  out  1  response present.
REQ-012 SHALL have ports: rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-013 SHALL have ports: rsp_rdata  out  32  read data, 0 for writes and errors.
REQ-014 SHALL have ports: rsp_err  out  1  misaligned or out-of-range access.
REQ-015 SHALL have ports: ram_en, ram_we[3:0], ram_addr[ADDR_W-1:0], ram_din[31:0]  out, and ram_dout[31:0]  in, forming one synchronous RAM port with 1-cycle read latency.

Function
REQ-016 SHALL implement the states IDLE, RD_WAIT and RESP, with at most one request outstanding.
REQ-017 SHALL drive req_ready=1 only in IDLE.
REQ-018 SHALL flag an accepted request as an error when req_addr[1:0]!=0 or req_addr[ADDR_W+1:2]>=DEPTH_WORDS.
REQ-019 SHALL, on acceptance of a valid read, drive ram_en=1, ram_we=0 and ram_addr=req_addr[ADDR_W+1:2] in the accept cycle T, then go to RD_WAIT.
REQ-020 SHALL, in RD_WAIT, capture ram_dout into the response register at the end of T+1, then go to RESP, so rsp_valid=1 from T+2.
REQ-021 SHALL, on acceptance of a valid write, drive ram_en=1, ram_we=req_wstrb, ram_din=req_wdata and ram_addr in cycle T, then go to RESP with rsp_rdata=0 and rsp_err=0, so rsp_valid=1 from T+1.
REQ-022 SHALL treat a write with req_wstrb=0 as a write that modifies no bytes and returns a normal response.
REQ-023 SHALL, on an error request, keep ram_en=0 and go to RESP with rsp_err=1 and rsp_rdata=0 from T+1.
REQ-024 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-025 SHALL not accept a new request in the cycle a response is consumed; the next acceptance is at the earliest on the following cycle.
REQ-026 SHALL drive ram_en=0 and ram_we=0 in every cycle other than a valid accept cycle.
REQ-027 SHALL produce responses in request order; ram_dout SHALL be sampled only in RD_WAIT.
REQ-028 SHALL accept the highest word (byte address 4*(DEPTH_WORDS-1)) as valid, and SHALL flag the next word as out-of-range with no wrap-around.

Reset
REQ-029 SHALL, while resetn=0, immediately force state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_en=0, ram_we=0, ram_addr=0 and ram_din=0.
REQ-030 SHALL discard any in-flight read or pending response on reset; a RAM write already clocked in cycle T is not undone.
REQ-031 SHALL assert req_ready in the first cycle after resetn deasserts.

Verification
REQ-032 SHALL cover: write addr 0x10, wdata 0xA5A5A5A5, wstrb 0xF, then read 0x10 -> ram_addr=4 in both accept cycles; read rsp_valid at T+2 with rdata 0xA5A5A5A5 and err=0.
REQ-033 SHALL cover: write 0x11223344 with wstrb 0xF, then write 0xFFFFFFFF with wstrb 0x5 to the same address, then read it back -> rdata 0x11FF33FF.
REQ-034 SHALL cover: read addr 0x2 and read addr 0x80000 -> ram_en never high; rsp_err=1 and rdata=0 at T+1. Read addr 0x7FFFC -> err=0.
REQ-035 SHALL cover: read response with rsp_ready held low for 5 cycles -> rsp_valid and rdata stable throughout; req_ready=0 throughout; a new request is accepted one cycle after the handshake.
REQ-036 SHALL cover: resetn pulsed low in RD_WAIT -> rsp_valid=0 with no response issued; req_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/ram_req_bridge.sv
// Single-outstanding request bridge onto one synchronous RAM port (1-cycle read latency).
// Accepted requests are range/alignment checked; errors never touch the RAM.
module ram_req_bridge #(
   parameter int unsigned DEPTH_WORDS = 131072,
   parameter int unsigned ADDR_W      = 19
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [3:0]        req_wstrb,
   input  logic [ADDR_W+1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

   // One extra bit so a depth of exactly 2**ADDR_W still compares correctly
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH_WORDS);

   state_t            state;
   logic [ADDR_W-1:0] word_addr;
   logic              req_err;
   logic              accept;

   assign word_addr = req_addr[ADDR_W+1:2];
   assign req_err   = (req_addr[1:0] != 2'b00) || ({1'b0, word_addr} >= DEPTH_LIM);
   // Gated by resetn so ready drops the instant reset asserts
   assign req_ready = resetn && (state == IDLE);
   assign accept    = req_valid && req_ready;

   // RAM port is driven only in the accept cycle of a valid request
   always_comb begin
      ram_en   = 1'b0;
      ram_we   = 4'b0000;
      ram_addr = '0;
      ram_din  = '0;
      if (accept && !req_err) begin
         ram_en   = 1'b1;
         ram_addr = word_addr;
         if (req_we) begin
            ram_we  = req_wstrb;
            ram_din = req_wdata;
         end
      end
   end

   // Request/response FSM with registered response outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  rsp_rdata <= '0;
                  if (req_err) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else if (req_we) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b0;
                  end else begin
                     state   <= RD_WAIT;
                     rsp_err <= 1'b0;
                  end
               end
            end
            RD_WAIT: begin
               rsp_rdata <= ram_dout;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               rsp_rdata <= '0;
               rsp_err   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_req_bridge.sv
// Bench for ram_req_bridge: behavioural RAM plus an associative-array reference memory.
module tb_ram_req_bridge;

   localparam int DEPTH = 131072;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [3:0]  req_wstrb;
   logic [20:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [18:0] ram_addr;
   logic [31:0] ram_din;
   logic [31:0] ram_dout;

   int n_cmp = 0;
   int n_bad = 0;
   logic mon_en = 1'b0;

   logic [31:0] ram_mem [0:524287];
   logic [31:0] ref_mem [int];

   ram_req_bridge #(.DEPTH_WORDS(DEPTH), .ADDR_W(19)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_wstrb (req_wstrb),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout)
   );

   always #5 clk = ~clk;

   // Synchronous RAM, 1-cycle read latency, byte-enabled writes
   always @(posedge clk) begin
      if (ram_en) begin
         ram_dout <= ram_mem[ram_addr];
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // RAM must only be enabled on an accepted request, and never written while disabled
   always @(negedge clk) begin
      if (mon_en)
         chk("ram_gate", {27'b0, ram_we & ~{4{ram_en}}, ram_en & ~(req_valid & req_ready)}, 32'h0);
   end

   function automatic logic [31:0] ref_read(input int w);
      return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
   endfunction

   function automatic void ref_write(input int w, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] v;
      v = ref_read(w);
      for (int b = 0; b < 4; b++)
         if (s[b]) v[8*b +: 8] = d[8*b +: 8];
      ref_mem[w] = v;
   endfunction

   task automatic do_req(input logic we, input logic [20:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int hold, output logic [31:0] got);
      logic        exp_err;
      logic [31:0] exp_rdata;
      logic [31:0] held_rdata;
      logic        held_err;
      int          word;
      int          lat;
      word      = int'(addr[20:2]);
      exp_err   = (addr[1:0] != 2'b00) || (word >= DEPTH);
      exp_rdata = 32'h0;
      if (!exp_err) begin
         if (we) ref_write(word, wdata, wstrb);
         else    exp_rdata = ref_read(word);
      end
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
      rsp_ready = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!req_ready && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("accept_ready", 32'(req_ready), 32'h1);
      chk("accept_ram_en", 32'(ram_en), 32'(!exp_err));
      chk("accept_ram_we", 32'(ram_we), (we && !exp_err) ? 32'(wstrb) : 32'h0);
      if (!exp_err) chk("accept_ram_addr", 32'(ram_addr), 32'(word));
      if (we && !exp_err) chk("accept_ram_din", ram_din, wdata);
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = 21'($urandom);
      req_wdata = $urandom; req_wstrb = 4'($urandom);
      lat = 0;
      @(negedge clk);
      while (!rsp_valid && lat < 10) begin
         chk("busy_ready", 32'(req_ready), 32'h0);
         @(negedge clk);
         lat++;
      end
      chk("rsp_latency", 32'(lat), (!exp_err && !we) ? 32'h1 : 32'h0);
      chk("rsp_valid", 32'(rsp_valid), 32'h1);
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      got        = rsp_rdata;
      held_rdata = rsp_rdata;
      held_err   = rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(rsp_valid), 32'h1);
         chk("hold_rdata", rsp_rdata, held_rdata);
         chk("hold_err", 32'(rsp_err), 32'(held_err));
         chk("hold_req_ready", 32'(req_ready), 32'h0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("hs_valid", 32'(rsp_valid), 32'h1);
      chk("hs_req_ready", 32'(req_ready), 32'h0);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("post_hs_valid", 32'(rsp_valid), 32'h0);
      chk("post_hs_ready", 32'(req_ready), 32'h1);
   endtask

   initial begin
      logic [31:0] got;
      logic [20:0] a;
      int          r;
      for (int i = 0; i < 524288; i++) ram_mem[i] = 32'h0;
      ram_dout  = 32'h0;
      resetn    = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_wstrb = 4'hF;
      req_addr  = 21'h10;
      req_wdata = 32'hDEADBEEF;
      rsp_ready = 1'b0;

      // Reset state, with a request pending on the inputs
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'h0);
      chk("rst_ram_en", 32'(ram_en), 32'h0);
      chk("rst_ram_we", 32'(ram_we), 32'h0);
      chk("rst_ram_addr", 32'(ram_addr), 32'h0);
      chk("rst_ram_din", ram_din, 32'h0);
      req_valid = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      chk("rel_req_ready", 32'(req_ready), 32'h1);

      // Write then read back word 4
      do_req(1'b1, 21'h10, 32'hA5A5A5A5, 4'hF, 0, got);
      do_req(1'b0, 21'h10, 32'h0, 4'h0, 0, got);
      chk("rd_0x10", got, 32'hA5A5A5A5);

      // Partial-strobe merge
      do_req(1'b1, 21'h20, 32'h11223344, 4'hF, 0, got);
      do_req(1'b1, 21'h20, 32'hFFFFFFFF, 4'h5, 0, got);
      do_req(1'b0, 21'h20, 32'h0, 4'h0, 0, got);
      chk("strobe_merge", got, 32'h11FF33FF);

      // Zero-strobe write leaves data intact
      do_req(1'b1, 21'h10, 32'h12345678, 4'h0, 0, got);
      do_req(1'b0, 21'h10, 32'h0, 4'h0, 0, got);
      chk("zero_strobe", got, 32'hA5A5A5A5);

      // Misaligned, out-of-range and top-word boundaries
      do_req(1'b0, 21'h2, 32'h0, 4'h0, 0, got);
      do_req(1'b0, 21'h80000, 32'h0, 4'h0, 0, got);
      do_req(1'b1, 21'h80000, 32'hCAFEF00D, 4'hF, 0, got);
      do_req(1'b0, 21'h7FFFC, 32'h0, 4'h0, 0, got);
      do_req(1'b1, 21'h7FFFC, 32'h0BADF00D, 4'hF, 0, got);
      do_req(1'b0, 21'h7FFFC, 32'h0, 4'h0, 0, got);
      chk("top_word", got, 32'h0BADF00D);

      // Back-pressure on a read response
      do_req(1'b0, 21'h10, 32'h0, 4'h0, 5, got);
      do_req(1'b0, 21'h20, 32'h0, 4'h0, 0, got);

      // Reset asserted while a read is in flight
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 21'h10;
      @(negedge clk);
      chk("rip_accept", 32'(ram_en), 32'h1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      chk("rip_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rip_req_ready", 32'(req_ready), 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b1;
      @(negedge clk);
      chk("rip_ram_en", 32'(ram_en), 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      resetn = 1'b1;
      @(negedge clk);
      chk("rip_rel_ready", 32'(req_ready), 32'h1);
      for (int i = 0; i < 3; i++) begin
         chk("rip_no_rsp", 32'(rsp_valid), 32'h0);
         @(negedge clk);
      end
      do_req(1'b0, 21'h10, 32'h0, 4'h0, 0, got);

      // Randomized traffic against the reference memory
      for (int n = 0; n < 150; n++) begin
         r = int'($urandom_range(0, 9));
         if (r <= 6)      a = 21'($urandom_range(0, 15) * 4);
         else if (r == 7) a = 21'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
         else if (r == 8) a = 21'((DEPTH + $urandom_range(0, 1000)) * 4);
         else             a = 21'h7FFFC;
         do_req(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), got);
      end

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
